glitch_sequencer: RTL and testbench
===================================

// Module: glitch_sequencer
// PURPOSE
//  Consumes the divided-clock output of the clock divider as a coarse timebase.
//  After arm and a trigger edge, waits a programmed number of ticks, then fires
//  N glitch pulses on glitch_out. Each pulse is a programmed number of clk
//  cycles wide, and pulses are separated by a programmed number of ticks.
//  Drives the glitch switch stage; arm, trigger and config come from the host.
// PARAMETERS
//  CNT_BITS   16  width of the delay_ticks and gap_ticks tick counters
//  WIDTH_BITS  8  width of pulse_width (clk cycles)
//  REP_BITS    4  width of num_pulses
// PORTS
//  clk          in   1           system clock
//  rst          in   1           reset, asynchronous, active-high
//  tick_in      in   1           divided clock (level toggle, clk-synchronous)
//  arm          in   1           arm request, sampled in IDLE only
//  abort        in   1           cancel any sequence
//  trigger      in   1           target trigger, already synchronised to clk
//  delay_ticks  in   CNT_BITS    ticks from trigger edge to first pulse
//  pulse_width  in   WIDTH_BITS  pulse width in clk cycles (0 treated as 1)
//  gap_ticks    in   CNT_BITS    ticks between pulses (0 treated as 1)
//  num_pulses   in   REP_BITS    pulses per sequence (0 = none)
//  glitch_out   out  1           glitch pulse, registered
//  armed        out  1           1 while in ARMED
//  busy         out  1           1 in DELAY, PULSE and GAP
//  done         out  1           one-cycle strobe at sequence end
// BEHAVIOUR
//  - Reset (async) clears FSM to IDLE, all counters, tick_q, trig_q and all outputs to 0.
//    glitch_out falls immediately, without waiting for a clock edge.
//  - tick = tick_in & ~tick_q, where tick_q is tick_in registered. One tick per tick_in
//    rising edge.
//  - trig_edge = trigger & ~trig_q, where trig_q is trigger registered.
//  - trig_q is updated in every state, so a trigger already high at arm time does not fire.
//  - Config is latched at the IDLE->ARMED transition. Input changes afterwards are ignored.
//  - FSM states: IDLE, ARMED, DELAY, PULSE, GAP, DONE. Outputs are registered and
//    change on the same clk edge as the state register.
//  - IDLE: arm=1 -> ARMED. If num_pulses==0, go to DONE instead.
//  - ARMED: trig_edge -> DELAY with cnt=delay_ticks. If delay_ticks==0, go directly
//    to PULSE, so glitch_out rises on the same edge that samples trig_edge.
//  - DELAY: cnt decrements on each tick. A tick while cnt==1 -> PULSE.
//    Result: glitch_out rises on the edge that samples the delay_ticks-th tick.
//  - PULSE: glitch_out=1 for exactly max(pulse_width,1) clk cycles; remaining pulses
//    decrement at pulse end. Then: remaining>0 -> GAP with cnt=max(gap_ticks,1);
//    otherwise -> DONE.
//  - GAP: glitch_out=0. cnt decrements on each tick. A tick while cnt==1 -> PULSE.
//  - DONE: done=1 for one cycle, then IDLE. The edge that leaves PULSE clears
//    glitch_out and sets done, so done follows the last pulse directly.
//  - abort=1 in any state -> IDLE on the next edge: glitch_out=0, armed=0, busy=0,
//    done stays 0. abort has priority over arm, trig_edge and tick.
//  - Trigger edges outside ARMED are ignored, so there is no retrigger while busy.
//    arm outside IDLE is ignored.
//  - A tick and a state transition in the same cycle: the tick is consumed only by
//    DELAY or GAP. Ticks seen in ARMED or PULSE are not counted.
//  - Counters never wrap. Each counter loads once, then decrements only while
//    its value is >=1.
// TESTING
//  1. Assert rst mid-PULSE without clk edges -> glitch_out, busy, done, armed all 0
//     immediately; FSM is in IDLE after release.
//  2. Divider DIV=16; arm with delay=3, width=5, num=1; pulse trigger -> glitch_out
//     rises on the 3rd tick after the edge, stays high 5 clk cycles, done=1 for 1 cycle
//     directly after.
//  3. num=3, width=2, gap=2 -> three 2-cycle pulses, rising 2 ticks apart; exactly
//     one done strobe.
//  4. delay=0, width=0 -> glitch_out high for exactly 1 cycle, starting on the
//     trig_edge edge. num=0 -> done 1 cycle after arm, with no pulse.
//  5. abort during DELAY and during PULSE -> glitch_out=0 and busy=0 next edge, no
//     done; a later trigger without re-arm gives no pulse.
//  6. trigger held high through arm -> no fire until it drops and rises again.
//     Extra trigger edges and config changes while busy leave timing unchanged.

Source files
------------

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: arm/trigger driven multi-pulse glitch generator timed by a divided-clock tick
module glitch_sequencer #(
  parameter int CNT_BITS = 16,
  parameter int WIDTH_BITS = 8,
  parameter int REP_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [CNT_BITS-1:0]   delay_ticks,
  input  logic [WIDTH_BITS-1:0] pulse_width,
  input  logic [CNT_BITS-1:0]   gap_ticks,
  input  logic [REP_BITS-1:0]   num_pulses,
  output logic                  glitch_out,
  output logic                  armed,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP, DONE} state_t;
  state_t state, state_n;
  logic tick_q, trig_q, tick, trig_edge;
  logic [CNT_BITS-1:0] cnt, cnt_n, delay_l, delay_n, gap_l, gap_n;
  logic [WIDTH_BITS-1:0] wcnt, wcnt_n, width_l, width_n;
  logic [REP_BITS-1:0] rem, rem_n;
  assign tick = tick_in & ~tick_q;
  assign trig_edge = trigger & ~trig_q;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    wcnt_n = wcnt;
    rem_n = rem;
    delay_n = delay_l;
    gap_n = gap_l;
    width_n = width_l;
    case (state)
      IDLE: if (arm) begin
        delay_n = delay_ticks;
        gap_n = gap_ticks | CNT_BITS'(~|gap_ticks);
        width_n = pulse_width | WIDTH_BITS'(~|pulse_width);
        rem_n = num_pulses;
        state_n = ~|num_pulses ? DONE : ARMED;
      end
      ARMED: if (trig_edge) begin
        state_n = ~|delay_l ? PULSE : DELAY;
        cnt_n = delay_l;
        wcnt_n = width_l;
      end
      DELAY, GAP: if (tick && |cnt) begin
        cnt_n = cnt - CNT_BITS'(1);
        if (cnt == CNT_BITS'(1)) begin
          state_n = PULSE;
          wcnt_n = width_l;
        end
      end
      PULSE: begin
        wcnt_n = |wcnt ? wcnt - WIDTH_BITS'(1) : wcnt;
        if (wcnt <= WIDTH_BITS'(1)) begin
          rem_n = |rem ? rem - REP_BITS'(1) : rem;
          state_n = rem > REP_BITS'(1) ? GAP : DONE;
          cnt_n = gap_l;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      cnt_n = '0;
      wcnt_n = '0;
      rem_n = '0;
    end
  end
  // outputs are decoded from the next state so they switch on the same edge as the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tick_q <= 1'b0;
      trig_q <= 1'b0;
      cnt <= '0;
      wcnt <= '0;
      rem <= '0;
      delay_l <= '0;
      gap_l <= '0;
      width_l <= '0;
      glitch_out <= 1'b0;
      armed <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tick_q <= tick_in;
      trig_q <= trigger;
      cnt <= cnt_n;
      wcnt <= wcnt_n;
      rem <= rem_n;
      delay_l <= delay_n;
      gap_l <= gap_n;
      width_l <= width_n;
      glitch_out <= state_n == PULSE;
      armed <= state_n == ARMED;
      busy <= state_n inside {DELAY, PULSE, GAP};
      done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: directed scenarios checked against a tick/pulse schedule model every cycle
module tb_glitch_sequencer;
  logic clk = 0, rst = 1, tick_in = 0, arm = 0, abort = 0, trigger = 0;
  logic [15:0] delay_ticks = 0, gap_ticks = 0;
  logic [7:0] pulse_width = 0;
  logic [3:0] num_pulses = 0;
  logic glitch_out, armed, busy, done;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, tk = 0, div = 0;
  int trig_tk, trig_cyc, a_cyc;
  bit trig_seen;
  int rises, rise_cyc, fall_cyc, done_cnt, done_cyc, last_width, run;
  int rise_tk [0:7];
  bit g_prev;
  bit m_tq, m_gq, m_armed, m_done;
  int wait_t, hi_left, pulses_left, delay_l, gap_l, width_l;

  glitch_sequencer dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .arm(arm), .abort(abort), .trigger(trigger),
    .delay_ticks(delay_ticks), .pulse_width(pulse_width), .gap_ticks(gap_ticks),
    .num_pulses(num_pulses), .glitch_out(glitch_out), .armed(armed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear();
    rises = 0;
    done_cnt = 0;
    last_width = 0;
    trig_seen = 0;
  endtask

  task automatic arm_cfg(input int d, input int w, input int g, input int n);
    delay_ticks = 16'(d);
    pulse_width = 8'(w);
    gap_ticks = 16'(g);
    num_pulses = 4'(n);
    arm = 1;
    a_cyc = cyc;
    step();
    arm = 0;
  endtask

  task automatic pulse_trig();
    trigger = 1;
    step(2);
    trigger = 0;
  endtask

  task automatic wait_glitch(input int lim);
    for (int k = 0; k < lim && !glitch_out; k++) step();
    chk("wait_glitch", int'(glitch_out), 1);
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    div++;
    tick_in = div[3];
  end

  // model: a sequence is "ticks still to wait" followed by "clk cycles still high"
  initial forever begin
    bit t, e, nd;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_tq = 0; m_gq = 0; m_armed = 0; m_done = 0;
      wait_t = 0; hi_left = 0; pulses_left = 0;
    end else begin
      t = tick_in && !m_tq;
      e = trigger && !m_gq;
      if (t) tk++;
      if (e && !trig_seen) begin
        trig_seen = 1;
        trig_tk = tk;
        trig_cyc = cyc;
      end
      nd = 0;
      if (abort) begin
        m_armed = 0; wait_t = 0; hi_left = 0; pulses_left = 0;
      end else if (hi_left > 0) begin
        hi_left--;
        if (hi_left == 0) begin
          pulses_left--;
          if (pulses_left > 0) wait_t = gap_l;
          else nd = 1;
        end
      end else if (wait_t > 0) begin
        if (t) begin
          wait_t--;
          if (wait_t == 0) hi_left = width_l;
        end
      end else if (m_armed) begin
        if (e) begin
          m_armed = 0;
          if (delay_l == 0) hi_left = width_l;
          else wait_t = delay_l;
        end
      end else if (!m_done && arm) begin
        delay_l = int'(delay_ticks);
        gap_l = gap_ticks == 0 ? 1 : int'(gap_ticks);
        width_l = pulse_width == 0 ? 1 : int'(pulse_width);
        if (num_pulses == 0) nd = 1;
        else begin
          m_armed = 1;
          pulses_left = int'(num_pulses);
        end
      end
      m_done = nd;
      m_tq = tick_in;
      m_gq = trigger;
    end
  end

  initial forever begin
    logic [3:0] exp;
    @(negedge clk);
    exp = rst ? 4'b0 : {hi_left > 0, m_armed, hi_left > 0 || wait_t > 0, m_done};
    chk("outputs{glitch,armed,busy,done}", int'({glitch_out, armed, busy, done}), int'(exp));
    if (glitch_out && !g_prev) begin
      if (rises < 8) rise_tk[rises] = tk;
      rise_cyc = cyc;
      rises++;
      run = 1;
    end else if (glitch_out) run++;
    if (!glitch_out && g_prev) begin
      last_width = run;
      fall_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    g_prev = glitch_out;
  end

  initial begin
    step(3);
    rst = 0;
    step(2);
    chk("reset_idle_armed", int'(armed), 0);
    chk("reset_idle_busy", int'(busy), 0);

    arm_cfg(1, 200, 0, 1);
    pulse_trig();
    wait_glitch(60);
    step(3);
    rst = 1;
    #1;
    chk("async_rst_glitch", int'(glitch_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_armed", int'(armed), 0);
    step();
    rst = 0;
    step(5);
    chk("post_rst_busy", int'(busy), 0);

    clear();
    arm_cfg(3, 5, 0, 1);
    chk("single_armed", int'(armed), 1);
    pulse_trig();
    step(80);
    chk("single_rises", rises, 1);
    chk("single_delay_ticks", rise_tk[0] - trig_tk, 3);
    chk("single_width", last_width, 5);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_done_follows", done_cyc, fall_cyc);

    clear();
    arm_cfg(1, 2, 2, 3);
    pulse_trig();
    step(130);
    chk("multi_rises", rises, 3);
    chk("multi_gap01", rise_tk[1] - rise_tk[0], 2);
    chk("multi_gap12", rise_tk[2] - rise_tk[1], 2);
    chk("multi_width", last_width, 2);
    chk("multi_done_cnt", done_cnt, 1);

    clear();
    arm_cfg(0, 0, 0, 1);
    step(2);
    pulse_trig();
    step(5);
    chk("zero_rise_on_trig", rise_cyc, trig_cyc);
    chk("zero_width", last_width, 1);
    chk("zero_done_cnt", done_cnt, 1);

    clear();
    arm_cfg(2, 3, 0, 0);
    step(3);
    chk("nopulse_done_cnt", done_cnt, 1);
    chk("nopulse_done_cycle", done_cyc, a_cyc + 1);
    chk("nopulse_rises", rises, 0);

    clear();
    arm_cfg(3, 4, 0, 1);
    pulse_trig();
    step(20);
    chk("abort_delay_busy_before", int'(busy), 1);
    abort = 1;
    step();
    abort = 0;
    chk("abort_delay_busy", int'(busy), 0);
    chk("abort_delay_glitch", int'(glitch_out), 0);
    step(80);
    pulse_trig();
    step(80);
    chk("abort_delay_rises", rises, 0);
    chk("abort_delay_done", done_cnt, 0);

    clear();
    arm_cfg(1, 50, 1, 2);
    pulse_trig();
    wait_glitch(40);
    step(3);
    abort = 1;
    step();
    abort = 0;
    chk("abort_pulse_glitch", int'(glitch_out), 0);
    chk("abort_pulse_busy", int'(busy), 0);
    step(60);
    pulse_trig();
    step(60);
    chk("abort_pulse_rises", rises, 1);
    chk("abort_pulse_done", done_cnt, 0);

    trigger = 1;
    step(2);
    clear();
    arm_cfg(1, 3, 1, 2);
    step(40);
    chk("held_trig_rises", rises, 0);
    chk("held_trig_armed", int'(armed), 1);
    trigger = 0;
    step();
    trigger = 1;
    step(5);
    delay_ticks = 9;
    pulse_width = 20;
    gap_ticks = 7;
    num_pulses = 5;
    for (int k = 0; k < 4; k++) begin
      trigger = ~trigger;
      step(3);
    end
    trigger = 0;
    step(60);
    chk("retrig_rises", rises, 2);
    chk("retrig_delay", rise_tk[0] - trig_tk, 1);
    chk("retrig_gap", rise_tk[1] - rise_tk[0], 1);
    chk("retrig_width", last_width, 3);
    chk("retrig_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
